// File: rtl/iter_divider_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       DivOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] DivResult;

  modport master (
    output Start, DivOp, SrcA, SrcB, Flush,
    input  Busy, Done, DivResult
  );

  modport slave (
    input  Start, DivOp, SrcA, SrcB, Flush,
    output Busy, Done, DivResult
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring DIV/DIVU/REM/REMU unit; WIDTH cycles per normal operation.
// Optional macro DIV_EARLY_OUT_EN short-cuts |SrcA| < |SrcB| through SPECIAL.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  iter_divider_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SPECIAL = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic             op_rem;
  logic             qsign;
  logic             rsign;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;

  logic             a_neg;
  logic             b_neg;
  logic             ovf;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_wide;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] dvd_n;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    a_neg = ~bus.DivOp[0] & bus.SrcA[WIDTH-1];
    b_neg = ~bus.DivOp[0] & bus.SrcB[WIDTH-1];
    mag_a = a_neg ? -bus.SrcA : bus.SrcA;
    mag_b = b_neg ? -bus.SrcB : bus.SrcB;
    ovf   = ~bus.DivOp[0] && (bus.SrcA == MIN_NEG) && (bus.SrcB == '1);

    // The dividend register doubles as the quotient: bits enter at the LSB as it shifts out.
    rem_wide = {rem, dvd[WIDTH-1]};
    diff     = rem_wide - {1'b0, dsr};
    q_bit    = ~diff[WIDTH];
    rem_n    = q_bit ? diff[WIDTH-1:0] : rem_wide[WIDTH-1:0];
    dvd_n    = {dvd[WIDTH-2:0], q_bit};
    q_fin    = qsign ? -dvd_n : dvd_n;
    r_fin    = rsign ? -rem_n : rem_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_rem <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      dvd    <= '0;
      rem    <= '0;
      dsr    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start && !bus.Flush) begin
            op_rem <= bus.DivOp[1];
            count  <= '0;
            dsr    <= mag_b;
            // Special results are stored already final, so sign correction is disabled.
            if (bus.SrcB == '0) begin
              state <= SPECIAL;
              dvd   <= '1;
              rem   <= bus.SrcA;
              qsign <= 1'b0;
              rsign <= 1'b0;
            end else if (ovf) begin
              state <= SPECIAL;
              dvd   <= MIN_NEG;
              rem   <= '0;
              qsign <= 1'b0;
              rsign <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            end else if (mag_a < mag_b) begin
              state <= SPECIAL;
              dvd   <= '0;
              rem   <= bus.SrcA;
              qsign <= 1'b0;
              rsign <= 1'b0;
`endif
            end else begin
              state <= RUN;
              dvd   <= mag_a;
              rem   <= '0;
              qsign <= a_neg ^ b_neg;
              rsign <= a_neg;
            end
          end else begin
            state <= IDLE;
          end
        end
        SPECIAL: begin
          if (bus.Flush) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            result <= op_rem ? rem : dvd;
          end
        end
        RUN: begin
          if (bus.Flush) begin
            state <= IDLE;
          end else begin
            rem   <= rem_n;
            dvd   <= dvd_n;
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state  <= DONE;
              result <= op_rem ? r_fin : q_fin;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = (state == RUN) || (state == SPECIAL);
  assign bus.Done      = (state == DONE);
  assign bus.DivResult = result;

endmodule

// File: tb/tb_iter_divider.sv
// Directed and randomized checks of iter_divider against an arithmetic reference model.
module tb_iter_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last_exp;

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit division with RV32M corner cases.
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (b == 0) begin
      q = -1;
      r = sa;
    end else if (!op[0] && a == MIN_NEG && b == '1) begin
      q = longint'($signed(MIN_NEG));
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    ref_div = op[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint ma, mb;
    ma = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    mb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 0 || (!op[0] && a == MIN_NEG && b == '1)) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`endif
    return W + 1;
  endfunction

  // Assumes the caller sits at a negedge; leaves the bench in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Start = 1'b1;
    bus.DivOp = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_check(input string tag, input int start_cyc, input logic [W-1:0] exp,
                            input int lat);
    int cyc = start_cyc;
    int busy = 0;
    while (bus.Done !== 1'b1 && cyc < 100) begin
      if (bus.Busy === 1'b1) busy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done"}, {31'b0, bus.Done}, 32'd1);
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy cycles"}, busy, lat - start_cyc);
    check({tag, " result"}, bus.DivResult, exp);
    last_exp = exp;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    @(negedge clk);
    issue(op, a, b);
    wait_check(tag, 1, exp, ref_lat(op, a, b));
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.Done === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    logic [1:0] op;
    logic [W-1:0] a, b;

    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.DivOp = 2'b00;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, bus.Busy}, 32'd0);
    check("reset done", {31'b0, bus.Done}, 32'd0);
    check("reset result", bus.DivResult, 32'd0);
    reset = 1'b0;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14);
    @(negedge clk);
    check("done one cycle", {31'b0, bus.Done}, 32'd0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2);
    run_op("div -7/2", 2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7/2", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run_op("rem 7/-2", 2'b10, 32'd7, -32'sd2, 32'd1);
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem 5/0", 2'b10, 32'd5, 32'd0, 32'd5);
    run_op("div ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
    run_op("rem ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
    run_op("divu 3/9", 2'b01, 32'd3, 32'd9, 32'd0);

    // Start while busy must be ignored.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.Start = 1'b1;
    bus.SrcA  = 32'd50;
    bus.SrcB  = 32'd5;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_check("start while busy", 6, 32'd14, W + 1);

    // Flush at cycle 15: no Done, result held.
    @(negedge clk);
    issue(2'b00, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    check("flush busy", {31'b0, bus.Busy}, 32'd0);
    count_done(40, pulses);
    check("flush no done", pulses, 0);
    check("flush result held", bus.DivResult, last_exp);

    // Back-to-back: new Start issued in the Done cycle.
    run_op("b2b first", 2'b01, 32'd100, 32'd7, 32'd14);
    issue(2'b01, 32'd9, 32'd3);
    wait_check("b2b divu 9/3", 1, 32'd3, W + 1);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = MIN_NEG; b = '1; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b, ref_div(op, a, b));
    end

    // Reset mid-RUN clears the result and suppresses Done.
    run_op("pre-reset", 2'b01, 32'd77, 32'd5, 32'd15);
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun reset busy", {31'b0, bus.Busy}, 32'd0);
    check("midrun reset done", {31'b0, bus.Done}, 32'd0);
    check("midrun reset result", bus.DivResult, 32'd0);
    count_done(40, pulses);
    check("midrun reset no done", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
